// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register front end.
// Covers the frame layout, the register addresses and the FSM state encoding.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned RW_BIT     = 15;
  localparam int unsigned ADDR_MSB   = 14;
  localparam int unsigned ADDR_LSB   = 8;

  localparam int unsigned ADDR_EN_OUT_LO = 0;
  localparam int unsigned ADDR_EN_OUT_HI = 1;
  localparam int unsigned ADDR_EN_PWM_LO = 2;
  localparam int unsigned ADDR_EN_PWM_HI = 3;
  localparam int unsigned ADDR_PWM_DUTY  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin.
// Emits single-cycle rise/fall pulses derived from one history flop behind the chain.
module sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    hist_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q[Stages-1];
  assign rise_o  = sync_q[Stages-1] & ~hist_q;
  assign fall_o  = ~sync_q[Stages-1] & hist_q;

endmodule

// File: rtl/spi_reg_frontend.sv
// Write-only SPI mode-0 peripheral that loads the PWM block's control registers.
// It oversamples the pins with clk and commits only complete, well-formed write frames.
module spi_reg_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_out_7_0,
  output logic [7:0] en_out_15_8,
  output logic [7:0] en_pwm_7_0,
  output logic [7:0] en_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  import spi_reg_pkg::*;

  localparam int unsigned CntW      = $clog2(FRAME_BITS + 2);
  localparam int unsigned SettleMax = SYNC_STAGES + 1;
  localparam int unsigned SettleW   = $clog2(SettleMax + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (sclk),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_copi (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (copi),
    .level_o (copi_level),
    .rise_o  (copi_rise),
    .fall_o  (copi_fall)
  );

  sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ncs (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .d_i     (ncs),
    .level_o (ncs_level),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

  state_e                state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [7:0]            regs_q [NUM_REGS];
  logic [7:0]            regs_d [NUM_REGS];
  logic                  frame_err_q, frame_err_d;
  logic                  armed_q, armed_d;
  logic [SettleW-1:0]    settle_q, settle_d;

  logic       settled;
  logic [6:0] addr;
  logic [7:0] data;
  logic       commit_ok;

  assign addr      = shift_q[ADDR_MSB:ADDR_LSB];
  assign data      = shift_q[7:0];
  assign settled   = (settle_q == SettleW'(SettleMax));
  assign commit_ok = (count_q == CntW'(FRAME_BITS)) && shift_q[RW_BIT] &&
                     ({25'd0, addr} < NUM_REGS);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    frame_err_d = 1'b0;
    settle_d    = settled ? settle_q : settle_q + SettleW'(1);
    // A frame already under way when reset lifts must not start a transfer:
    // only accept ncs falls once the synchronised ncs has been seen idle-high.
    armed_d     = armed_q | (settled & ncs_level);

    case (state_q)
      StIdle: begin
        if (armed_q && ncs_fall) begin
          state_d = StShift;
          count_d = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_level};
          if (count_q != CntW'(FRAME_BITS + 1)) count_d = count_q + CntW'(1);
        end
        if (ncs_rise) state_d = StCommit;
      end
      StCommit: begin
        if (commit_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) regs_d[i] = data;
          end
        end else begin
          frame_err_d = 1'b1;
        end
        if (ncs_fall) begin
          state_d = StShift;
          count_d = '0;
          shift_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign en_out_7_0     = regs_q[ADDR_EN_OUT_LO];
  assign en_out_15_8    = regs_q[ADDR_EN_OUT_HI];
  assign en_pwm_7_0     = regs_q[ADDR_EN_PWM_LO];
  assign en_pwm_15_8    = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle = regs_q[ADDR_PWM_DUTY];
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Directed bench for spi_reg_frontend: SPI frames bit-banged at clk/8 with fixed expectations.
`timescale 1ns / 1ps
module tb_spi_reg_frontend;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_out_7_0;
  logic [7:0] en_out_15_8;
  logic [7:0] en_pwm_7_0;
  logic [7:0] en_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_err;

  int n_cmp   = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int exp_err = 0;

  spi_reg_frontend dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_out_7_0     (en_out_7_0),
    .en_out_15_8    (en_out_15_8),
    .en_pwm_7_0     (en_pwm_7_0),
    .en_pwm_15_8    (en_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame_err is registered, so it is high for exactly one full period per pulse.
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    ncs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    ncs = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = data[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] data, input int nbits);
    cs_low();
    send_bits(data, nbits);
    cs_high();
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp);
    check_eq({tag, "_r0"}, {24'd0, en_out_7_0},     {24'd0, exp[7:0]});
    check_eq({tag, "_r1"}, {24'd0, en_out_15_8},    {24'd0, exp[15:8]});
    check_eq({tag, "_r2"}, {24'd0, en_pwm_7_0},     {24'd0, exp[23:16]});
    check_eq({tag, "_r3"}, {24'd0, en_pwm_15_8},    {24'd0, exp[31:24]});
    check_eq({tag, "_r4"}, {24'd0, pwm_duty_cycle}, {24'd0, exp[39:32]});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] wr_frames [4];

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    check_regs("reset", 40'h00_00_00_00_00);
    check_eq("reset_ferr", {31'd0, frame_err}, 32'd0);

    // First write: update lands exactly 4 clk after the ncs pin rises.
    cs_low();
    send_bits(32'h80F0, 16);
    cs_high();
    wait_clk(3);
    check_eq("lat_early", {24'd0, en_out_7_0}, 32'h00);
    wait_clk(1);
    check_eq("lat_f0", {24'd0, en_out_7_0}, 32'hF0);
    wait_clk(6);
    check_regs("first", 40'h00_00_00_00_F0);

    wr_frames[0] = 16'h81AA;
    wr_frames[1] = 16'h8255;
    wr_frames[2] = 16'h8301;
    wr_frames[3] = 16'h8480;
    for (int k = 0; k < 4; k++) begin
      frame({16'd0, wr_frames[k]}, 16);
      wait_clk(8);
    end
    check_regs("wr4", 40'h80_01_55_AA_F0);
    check_eq("wr4_err", err_cnt, exp_err);

    // Out-of-range address and read frame: each discarded with one pulse.
    frame(32'h85FF, 16);
    wait_clk(8);
    exp_err++;
    check_eq("addr5_err", err_cnt, exp_err);
    frame(32'h0012, 16);
    wait_clk(8);
    exp_err++;
    check_eq("read_err", err_cnt, exp_err);
    check_regs("bad", 40'h80_01_55_AA_F0);

    // 15-bit and 17-bit frames to register 0.
    frame(32'h4061, 15);
    wait_clk(8);
    exp_err++;
    check_eq("short_err", err_cnt, exp_err);
    frame(32'h10155, 17);
    wait_clk(8);
    exp_err++;
    check_eq("long_err", err_cnt, exp_err);
    check_eq("len_r0", {24'd0, en_out_7_0}, 32'hF0);

    frame(32'h80C3, 16);
    wait_clk(8);
    check_eq("c3_r0", {24'd0, en_out_7_0}, 32'hC3);
    check_eq("c3_err", err_cnt, exp_err);

    // ncs pulse with no SCLK edges.
    cs_low();
    cs_high();
    wait_clk(8);
    exp_err++;
    check_eq("empty_err", err_cnt, exp_err);
    check_regs("empty", 40'h80_01_55_AA_C3);

    // Reset in the middle of a frame; the tail of that frame must be ignored.
    cs_low();
    send_bits(32'h84, 8);
    @(negedge clk);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    send_bits(32'h33, 8);
    cs_high();
    wait_clk(8);
    check_regs("midrst", 40'h00_00_00_00_00);
    check_eq("midrst_err", err_cnt, exp_err);

    frame(32'h8433, 16);
    wait_clk(8);
    check_regs("after_rst", 40'h33_00_00_00_00);

    // Back-to-back frames separated by a single clk of ncs high.
    frame(32'h8311, 16);
    frame(32'h8312, 16);
    wait_clk(8);
    check_eq("b2b_r3", {24'd0, en_pwm_15_8}, 32'h12);
    frame(32'h8221, 16);
    frame(32'h8122, 16);
    wait_clk(8);
    check_regs("b2b", 40'h33_12_21_22_00);
    check_eq("b2b_err", err_cnt, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
